hue_cycle_controller: RTL and testbench
=======================================

Name: hue_cycle_controller

Overview:
- Sequences three fade ramps (R, G, B) around a 6-segment colour wheel, so an RGB LED cycles continuously through hue.
- Each segment ramps exactly one channel up or down; the other two channels hold at full or off.
- Owns the step timing, the segment state machine, and three glitch-free PWM outputs driven from one shared PWM counter.
- Sits between the top level and the RGB LED pins.

Parameters:
- CLK_PER_STEP, 12000: clk cycles per ramp step (1 ms at 12 MHz).
- STEPS_PER_SEG, 166: ramp steps per segment.
- PWM_INTERVAL, 1200: PWM period in clk cycles.
- STEP_VAL, PWM_INTERVAL/STEPS_PER_SEG: duty change per step (integer division).
- MAX_DUTY, STEP_VAL*STEPS_PER_SEG: full-on duty value (1162 at defaults).

Ports:
- clk, in, 1: system clock; the only clock.
- rst, in, 1: reset, asynchronous, active-high.
- enable, in, 1: run; 0 stops the sequencer and forces LEDs off.
- hold, in, 1: freeze the ramp; PWM keeps running at the current duty.
- duty_r / duty_g / duty_b, out, $clog2(PWM_INTERVAL) each: current duty values.
- led_r / led_g / led_b, out, 1 each: PWM outputs, active-high.
- segment, out, 3: current wheel segment, 0..5.
- seg_done, out, 1: one-cycle pulse on each segment advance.

Behaviour:
- Reset (async, while rst=1):
  - segment=0, step count=0, prescaler=0, PWM counter=0.
  - duty_r=MAX_DUTY, duty_g=0, duty_b=0.
  - Shadow duties=0; led_*=0; seg_done=0.
- Prescaler:
  - Advances only when enable=1 and hold=0; otherwise holds its value.
  - Internal step_tick is a one-cycle pulse when prescaler==CLK_PER_STEP-1; the prescaler wraps to 0 on that cycle.
  - Everything runs on clk; no derived clocks.
- Segment table (ramping channel; held channels):
  - 0: G up; R=MAX, B=0.
  - 1: R down; G=MAX, B=0.
  - 2: B up; G=MAX, R=0.
  - 3: G down; B=MAX, R=0.
  - 4: R up; B=MAX, G=0.
  - 5: B down; R=MAX, G=0.
- On step_tick: the ramping channel moves by ±STEP_VAL and the step count increments.
- Segment advance (step count==STEPS_PER_SEG-1 at a step_tick):
  - Step count clears to 0.
  - segment advances (5 wraps to 0).
  - seg_done=1 for exactly the following cycle.
  - The finished ramp lands exactly on MAX_DUTY or 0.
  - Held channels are re-snapped to their table values on the advance; no accumulated drift.
- Arithmetic: no saturation is needed because the ramp endpoints are exact; a duty never leaves 0..MAX_DUTY.
- PWM:
  - One shared counter runs 0..PWM_INTERVAL-1 and wraps.
  - Each channel latches duty_* into its shadow when the counter==PWM_INTERVAL-1, so a duty change takes effect only at a period boundary.
  - led_x is registered as (counter < shadow_x): 1-cycle latency from the counter.
  - Duty 0 keeps the LED constantly low.
- enable=0:
  - PWM counter is held at 0 and led_* are forced to 0 on the next edge.
  - duty_*, segment, step count and prescaler are retained.
  - On re-enable the sequence resumes where it stopped.
- hold=1: duties are frozen and the PWM continues; releasing hold resumes the prescaler from its held value.
- hold and enable changing on the same cycle as a step_tick: the tick is suppressed (the gating is combinational on the current inputs).
- rst asserted mid-operation: immediate return to the reset values above.

Decomposition:
- Package hue_pkg holds:
  - the segment enum (SEG_G_UP..SEG_B_DN, 3 bits);
  - per-segment ramp-channel index and direction;
  - held-channel table constants.
- Sub-module pwm_channel: shadow register plus compare, instanced 3× on the shared counter.

Test Plan:
- Bench parameters: CLK_PER_STEP=4, STEPS_PER_SEG=5, PWM_INTERVAL=20, giving STEP_VAL=4 and MAX_DUTY=20.
- Reset release with enable=1 -> duties (20,0,0) and segment=0. At the 4th enabled clk, duty_g=4; after 20 cycles, duty_g=20, segment=1 and seg_done high for exactly 1 cycle.
- Run 120 enabled cycles -> segments visit 0..5 in order. Duties at the advances are (20,20,0), (0,20,0), (0,20,20), (0,0,20), (20,0,20), and finally (20,0,0) with segment=0.
- Duty write of 8 mid-period -> the current period still uses the old shadow. The next period gives led high 8 of 20 cycles, 1 cycle behind the counter; duty 0 gives 0 high cycles.
- hold=1 for 50 cycles mid-segment 2 -> duty_b, segment and step count unchanged; PWM still toggles. On release, the next step_tick arrives after the remaining prescaler count.
- enable=0 for 30 cycles -> led_*=0 from the next edge and duties retained. On re-enable, PWM restarts with the counter at 0.
- rst pulsed asynchronously (between clk edges) mid-segment 4 -> outputs immediately at the reset values; the sequence restarts at segment 0.

Source files
------------

// File: rtl/hue_pkg.sv
// Colour-wheel tables for the hue sequencer: segment encoding, which channel
// ramps in each segment and in which direction, and which channels sit at full.
package hue_pkg;

  typedef enum logic [2:0] {
    SEG_G_UP = 3'd0,
    SEG_R_DN = 3'd1,
    SEG_B_UP = 3'd2,
    SEG_G_DN = 3'd3,
    SEG_R_UP = 3'd4,
    SEG_B_DN = 3'd5
  } seg_e;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  // Held-channel masks, bit index = channel (bit0 R, bit1 G, bit2 B)
  localparam logic [2:0] HELD_G_UP = 3'b001;
  localparam logic [2:0] HELD_R_DN = 3'b010;
  localparam logic [2:0] HELD_B_UP = 3'b010;
  localparam logic [2:0] HELD_G_DN = 3'b100;
  localparam logic [2:0] HELD_R_UP = 3'b100;
  localparam logic [2:0] HELD_B_DN = 3'b001;

  function automatic logic [1:0] ramp_ch(seg_e s);
    case (s)
      SEG_G_UP, SEG_G_DN: ramp_ch = CH_G;
      SEG_R_DN, SEG_R_UP: ramp_ch = CH_R;
      default:            ramp_ch = CH_B;
    endcase
  endfunction

  function automatic logic ramp_up(seg_e s);
    ramp_up = (s == SEG_G_UP) || (s == SEG_B_UP) || (s == SEG_R_UP);
  endfunction

  function automatic logic [2:0] held_full(seg_e s);
    case (s)
      SEG_G_UP: held_full = HELD_G_UP;
      SEG_R_DN: held_full = HELD_R_DN;
      SEG_B_UP: held_full = HELD_B_UP;
      SEG_G_DN: held_full = HELD_G_DN;
      SEG_R_UP: held_full = HELD_R_UP;
      default:  held_full = HELD_B_DN;
    endcase
  endfunction

  // Whether channel ch sits at full duty once segment s has completed
  function automatic logic end_full(seg_e s, logic [1:0] ch);
    logic [2:0] mask;
    mask = held_full(s);
    if (ch == ramp_ch(s)) end_full = ramp_up(s);
    else                  end_full = mask[ch];
  endfunction

  function automatic seg_e next_seg(seg_e s);
    next_seg = (s == SEG_B_DN) ? SEG_G_UP : seg_e'(s + 3'd1);
  endfunction

endpackage

// File: rtl/hue_cycle_controller_if.sv
// Control inputs and LED/status outputs of the hue sequencer.
interface hue_cycle_controller_if #(
  parameter int PWM_INTERVAL = 1200
) ();
  localparam int DW = $clog2(PWM_INTERVAL);

  logic          enable;
  logic          hold;
  logic [DW-1:0] duty_r;
  logic [DW-1:0] duty_g;
  logic [DW-1:0] duty_b;
  logic          led_r;
  logic          led_g;
  logic          led_b;
  logic [2:0]    segment;
  logic          seg_done;

  modport master (
    output enable, hold,
    input  duty_r, duty_g, duty_b, led_r, led_g, led_b, segment, seg_done
  );

  modport slave (
    input  enable, hold,
    output duty_r, duty_g, duty_b, led_r, led_g, led_b, segment, seg_done
  );
endinterface

// File: rtl/hue_cycle_controller_pwm_channel.sv
// One PWM output: duty is shadowed at the period boundary so a duty change
// never produces a truncated or stretched pulse.
module pwm_channel #(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [DW-1:0] cnt_i,
  input  logic [DW-1:0] duty_i,
  output logic          led_o
);
  logic [DW-1:0] shadow_q;
  logic          led_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      if (load_i) shadow_q <= duty_i;
      led_q <= en_i && (cnt_i < shadow_q);
    end
  end

  assign led_o = led_q;
endmodule

// File: rtl/hue_cycle_controller.sv
// Hue-wheel sequencer: prescaled step timing, six-segment ramp FSM and three
// PWM outputs sharing one period counter.
module hue_cycle_controller
  import hue_pkg::*;
#(
  parameter int CLK_PER_STEP  = 12000,
  parameter int STEPS_PER_SEG = 166,
  parameter int PWM_INTERVAL  = 1200
) (
  input logic             clk,
  input logic             rst,
  hue_cycle_controller_if.slave bus
);
  localparam int STEP_VAL = PWM_INTERVAL / STEPS_PER_SEG;
  localparam int MAX_DUTY = STEP_VAL * STEPS_PER_SEG;
  localparam int DW = $clog2(PWM_INTERVAL);
  localparam int PW = (CLK_PER_STEP > 1) ? $clog2(CLK_PER_STEP) : 1;
  localparam int SW = (STEPS_PER_SEG > 1) ? $clog2(STEPS_PER_SEG) : 1;
  localparam logic [DW-1:0] MAX_D  = DW'(MAX_DUTY);
  localparam logic [DW-1:0] STEP_D = DW'(STEP_VAL);

  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   step_q, step_d;
  seg_e            seg_q, seg_d;
  logic            seg_done_q;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            run, step_tick, last_step, pwm_load;
  logic [3*DW-1:0] duty_all;
  logic [2:0]      led_all;

  // Gating is on the live inputs, so a tick coinciding with hold/enable is dropped
  always_comb begin
    run       = bus.enable && !bus.hold;
    step_tick = run && (presc_q == PW'(CLK_PER_STEP - 1));
    last_step = step_tick && (step_q == SW'(STEPS_PER_SEG - 1));

    presc_d = presc_q;
    if (run) presc_d = step_tick ? '0 : presc_q + PW'(1);

    step_d = step_q;
    seg_d  = seg_q;
    if (last_step) begin
      step_d = '0;
      seg_d  = next_seg(seg_q);
    end else if (step_tick) begin
      step_d = step_q + SW'(1);
    end

    pwm_load = (cnt_q == DW'(PWM_INTERVAL - 1));
    cnt_d    = '0;
    if (bus.enable) cnt_d = pwm_load ? '0 : cnt_q + DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      step_q     <= '0;
      seg_q      <= SEG_G_UP;
      seg_done_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      step_q     <= step_d;
      seg_q      <= seg_d;
      seg_done_q <= last_step;
      cnt_q      <= cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      localparam logic [DW-1:0] RST_VAL = (gi == 0) ? MAX_D : '0;
      logic [DW-1:0] duty_q, duty_d;

      // Final step snaps all three channels to the segment's end values
      always_comb begin
        duty_d = duty_q;
        if (last_step)
          duty_d = end_full(seg_q, 2'(gi)) ? MAX_D : '0;
        else if (step_tick && (ramp_ch(seg_q) == 2'(gi)))
          duty_d = ramp_up(seg_q) ? duty_q + STEP_D : duty_q - STEP_D;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) duty_q <= RST_VAL;
        else     duty_q <= duty_d;
      end

      pwm_channel #(.DW(DW)) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .en_i   (bus.enable),
        .load_i (pwm_load),
        .cnt_i  (cnt_q),
        .duty_i (duty_q),
        .led_o  (led_all[gi])
      );

      assign duty_all[gi*DW +: DW] = duty_q;
    end
  endgenerate

  assign bus.duty_r   = duty_all[0*DW +: DW];
  assign bus.duty_g   = duty_all[1*DW +: DW];
  assign bus.duty_b   = duty_all[2*DW +: DW];
  assign bus.led_r    = led_all[0];
  assign bus.led_g    = led_all[1];
  assign bus.led_b    = led_all[2];
  assign bus.segment  = seg_q;
  assign bus.seg_done = seg_done_q;
endmodule

// File: tb/tb_hue_cycle_controller.sv
// Self-checking bench for hue_cycle_controller against an arithmetic model of
// the colour wheel and PWM period.
module tb_hue_cycle_controller;
  localparam int CPS  = 4;
  localparam int SPS  = 5;
  localparam int PI   = 20;
  localparam int STEP = PI / SPS;
  localparam int MAXD = STEP * SPS;
  localparam int SEGC = CPS * SPS;

  // Segment start duties (R,G,B), ramping channel and direction per segment
  localparam int START [6][3] = '{'{MAXD, 0, 0}, '{MAXD, MAXD, 0}, '{0, MAXD, 0},
                                  '{0, MAXD, MAXD}, '{0, 0, MAXD}, '{MAXD, 0, MAXD}};
  localparam int RCH [6] = '{1, 0, 2, 1, 0, 2};
  localparam int RDIR [6] = '{1, -1, 1, -1, 1, -1};

  logic clk = 1'b0;
  logic rst = 1'b1;

  hue_cycle_controller_if #(.PWM_INTERVAL(PI)) bus ();

  hue_cycle_controller #(
    .CLK_PER_STEP (CPS),
    .STEPS_PER_SEG(SPS),
    .PWM_INTERVAL (PI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   run_cyc;
  int   pcnt;
  int   shadow [3];
  logic led_exp [3];
  logic sd_exp;

  function automatic int seg_of(int rc);
    return (rc / CPS / SPS) % 6;
  endfunction

  function automatic int duty_of(int rc, int ch);
    int steps, s, k, v;
    steps = rc / CPS;
    s = (steps / SPS) % 6;
    k = steps % SPS;
    v = START[s][ch];
    if (ch == RCH[s]) v = v + RDIR[s] * k * STEP;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    run_cyc = 0;
    pcnt    = 0;
    sd_exp  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      shadow[c]  = 0;
      led_exp[c] = 1'b0;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".segment"}, 32'(bus.segment), seg_of(run_cyc));
    chk({ph, ".duty_r"}, 32'(bus.duty_r), duty_of(run_cyc, 0));
    chk({ph, ".duty_g"}, 32'(bus.duty_g), duty_of(run_cyc, 1));
    chk({ph, ".duty_b"}, 32'(bus.duty_b), duty_of(run_cyc, 2));
    chk({ph, ".seg_done"}, 32'(bus.seg_done), 32'(sd_exp));
    chk({ph, ".led_r"}, 32'(bus.led_r), 32'(led_exp[0]));
    chk({ph, ".led_g"}, 32'(bus.led_g), 32'(led_exp[1]));
    chk({ph, ".led_b"}, 32'(bus.led_b), 32'(led_exp[2]));
  endtask

  // One clock with the given inputs; model advances on the edge, DUT checked 1 later
  task automatic cyc(input string ph, input logic en, input logic hd);
    bus.enable = en;
    bus.hold   = hd;
    @(posedge clk);
    for (int c = 0; c < 3; c++) led_exp[c] = en && (pcnt < shadow[c]);
    if (pcnt == PI - 1)
      for (int c = 0; c < 3; c++) shadow[c] = duty_of(run_cyc, c);
    pcnt   = en ? (pcnt + 1) % PI : 0;
    sd_exp = en && !hd && ((run_cyc + 1) % SEGC == 0);
    if (en && !hd) run_cyc++;
    #1;
    check_all(ph);
    $display("cyc t=%0t %s en=%0b hold=%0b seg=%0d duty=(%0d,%0d,%0d) led=%0b%0b%0b sd=%0b",
             $time, ph, en, hd, bus.segment, bus.duty_r, bus.duty_g, bus.duty_b,
             bus.led_r, bus.led_g, bus.led_b, bus.seg_done);
  endtask

  initial begin
    int  target;
    logic reached;
    int  r;

    bus.enable = 1'b1;
    bus.hold   = 1'b0;
    reset_model();

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3 rst = 1'b0;

    // First step lands on the 4th enabled edge; segment ends after 20
    repeat (3) cyc("start", 1'b1, 1'b0);
    chk("g_before_tick", 32'(bus.duty_g), 0);
    cyc("start", 1'b1, 1'b0);
    chk("g_first_step", 32'(bus.duty_g), STEP);
    repeat (16) cyc("seg0", 1'b1, 1'b0);
    chk("seg1_entered", 32'(bus.segment), 1);
    chk("g_full", 32'(bus.duty_g), MAXD);
    chk("seg_done_pulse", 32'(bus.seg_done), 1);
    cyc("seg1", 1'b1, 1'b0);
    chk("seg_done_clear", 32'(bus.seg_done), 0);

    // Full wheel: back to segment 0 after 120 enabled cycles
    for (int i = 0; i < 200 && run_cyc < 6 * SEGC; i++) cyc("wheel", 1'b1, 1'b0);
    chk("wheel_seg", 32'(bus.segment), 0);
    chk("wheel_r", 32'(bus.duty_r), MAXD);
    chk("wheel_g", 32'(bus.duty_g), 0);
    chk("wheel_b", 32'(bus.duty_b), 0);

    // Hold mid-segment 2 with the prescaler at 2
    target = 6 * SEGC + 2 * SEGC + 2 * CPS + 2;
    for (int i = 0; i < 200 && run_cyc < target; i++) cyc("to_hold", 1'b1, 1'b0);
    chk("hold_reached", 32'(run_cyc), target);
    repeat (50) cyc("hold", 1'b1, 1'b1);
    chk("hold_duty_b", 32'(bus.duty_b), 2 * STEP);
    chk("hold_segment", 32'(bus.segment), 2);
    cyc("release", 1'b1, 1'b0);
    chk("release_no_tick", 32'(bus.duty_b), 2 * STEP);
    cyc("release", 1'b1, 1'b0);
    chk("release_tick", 32'(bus.duty_b), 3 * STEP);

    // Disable: LEDs off on the next edge, state retained
    cyc("disable", 1'b0, 1'b0);
    chk("dis_led_g", 32'(bus.led_g), 0);
    repeat (29) cyc("disable", 1'b0, 1'b0);
    repeat (45) cyc("reenable", 1'b1, 1'b0);

    // Randomised enable/hold mix
    repeat (300) begin
      r = int'($urandom_range(0, 9));
      cyc("random", r != 0, (r == 1) || (r == 2));
    end

    // Asynchronous reset pulse mid-segment 4
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      cyc("to_seg4", 1'b1, 1'b0);
      reached = (seg_of(run_cyc) == 4) && (run_cyc % SEGC == 2 * CPS + 1);
    end
    chk("seg4_reached", 32'(reached), 1);
    #3 rst = 1'b1;
    #1;
    reset_model();
    check_all("async_rst");
    #2 rst = 1'b0;
    repeat (30) cyc("restart", 1'b1, 1'b0);
    chk("restart_seg", 32'(bus.segment), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
